// File: rtl/serial_sub_ctrl.sv
// Bit-serial subtractor: one full-subtract stage built from two half
// subtractors and a borrow flop, sequenced by an IDLE/RUN/DONE FSM.
module serial_sub_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] sa_q, sa_d;
  logic [WIDTH-1:0] sb_q, sb_d;
  logic [WIDTH-1:0] sr_q, sr_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             bw_q, bw_d;
  logic             bo_q, bo_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic             ai, bi;
  logic             hd, hb1, hb2;
  logic             d, bn;
  logic             last;
  logic [WIDTH-1:0] sr_sh;

  // Two half-subtractor cells; the second folds in the stored borrow.
  assign ai  = sa_q[0];
  assign bi  = sb_q[0];
  assign hd  = ai ^ bi;
  assign hb1 = ~ai & bi;
  assign d   = hd ^ bw_q;
  assign hb2 = ~hd & bw_q;
  assign bn  = hb1 | hb2;

  assign sr_sh = {d, sr_q[WIDTH-1:1]};
  assign last  = (cnt_q == CW'(WIDTH - 1));

  always_comb begin
    state_d = state_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    sr_d    = sr_q;
    diff_d  = diff_q;
    bw_d    = bw_q;
    bo_d    = bo_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (start) begin
          sa_d    = a;
          sb_d    = b;
          bw_d    = 1'b0;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        sr_d  = sr_sh;
        sa_d  = sa_q >> 1;
        sb_d  = sb_q >> 1;
        bw_d  = bn;
        cnt_d = cnt_q + CW'(1);
        if (last) begin
          diff_d  = sr_sh;
          bo_d    = bn;
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      sa_q    <= '0;
      sb_q    <= '0;
      sr_q    <= '0;
      diff_q  <= '0;
      bw_q    <= 1'b0;
      bo_q    <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      sr_q    <= sr_d;
      diff_q  <= diff_d;
      bw_q    <= bw_d;
      bo_q    <= bo_d;
      cnt_q   <= cnt_d;
    end
  end

  assign busy       = (state_q == RUN);
  assign done       = (state_q == DONE);
  assign diff       = diff_q;
  assign borrow_out = bo_q;

endmodule

// File: tb/tb_serial_sub_ctrl.sv
// Scoreboard bench for serial_sub_ctrl at WIDTH=8 and WIDTH=16.
// Stimulus pushes expected {borrow,diff} and done cycle; monitor pops.
module tb_serial_sub_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        start8, start16;
  logic [7:0]  a8, b8, diff8;
  logic [15:0] a16, b16, diff16;
  logic        busy8, done8, borrow8;
  logic        busy16, done16, borrow16;

  always #5 clk = ~clk;

  serial_sub_ctrl #(.WIDTH(8)) u8 (
    .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .diff(diff8), .borrow_out(borrow8)
  );

  serial_sub_ctrl #(.WIDTH(16)) u16 (
    .clk(clk), .rst(rst), .start(start16), .a(a16), .b(b16),
    .busy(busy16), .done(done16), .diff(diff16), .borrow_out(borrow16)
  );

  typedef struct {
    logic [16:0] v;
    int          t;
  } exp_t;

  exp_t q8[$];
  exp_t q16[$];
  exp_t e8, e16;
  int   cyc = 0;
  int   n_vec = 0;
  int   n_err = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!rst && done8) begin
      n_vec++;
      if (q8.size() == 0) begin
        n_err++;
        $display("FAIL done8_unexpected got diff=%h @%0d", diff8, cyc);
      end else begin
        e8 = q8.pop_front();
        if ({borrow8, diff8} !== e8.v[8:0] || cyc != e8.t) begin
          n_err++;
          $display("FAIL res8 got %b_%h @%0d expected %b_%h @%0d",
                   borrow8, diff8, cyc, e8.v[8], e8.v[7:0], e8.t);
        end
      end
    end
    if (!rst && done16) begin
      n_vec++;
      if (q16.size() == 0) begin
        n_err++;
        $display("FAIL done16_unexpected got diff=%h @%0d", diff16, cyc);
      end else begin
        e16 = q16.pop_front();
        if ({borrow16, diff16} !== e16.v || cyc != e16.t) begin
          n_err++;
          $display("FAIL res16 got %b_%h @%0d expected %b_%h @%0d",
                   borrow16, diff16, cyc, e16.v[16], e16.v[15:0], e16.t);
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %h expected %h @%0d", nm, got, exp, cyc);
    end
  endtask

  task automatic op(input bit w16, input logic [15:0] a, input logic [15:0] b,
                    input logic [16:0] exp);
    int w;
    w = w16 ? 16 : 8;
    @(negedge clk);
    if (w16) begin
      a16 = a; b16 = b; start16 = 1'b1;
    end else begin
      a8 = a[7:0]; b8 = b[7:0]; start8 = 1'b1;
    end
    @(posedge clk);
    #1;
    start8  = 1'b0;
    start16 = 1'b0;
    if (w16) q16.push_back('{exp, cyc + w});
    else     q8.push_back('{exp, cyc + w});
    for (int i = 0; i < w; i++) begin
      @(negedge clk);
      chk("busy_run", {31'd0, w16 ? busy16 : busy8}, 1);
      chk("done_run", {31'd0, w16 ? done16 : done8}, 0);
    end
    @(negedge clk);
    chk("busy_done", {31'd0, w16 ? busy16 : busy8}, 0);
    chk("done_pulse", {31'd0, w16 ? done16 : done8}, 1);
  endtask

  logic [8:0]  m8;
  logic [16:0] m16;
  int          t0;

  initial begin
    rst = 1'b1;
    start8 = 1'b0; start16 = 1'b0;
    a8 = '0; b8 = '0; a16 = '0; b16 = '0;
    #1;
    chk("rst_busy8", {31'd0, busy8}, 0);
    chk("rst_done8", {31'd0, done8}, 0);
    chk("rst_res8", {23'd0, borrow8, diff8}, 0);
    chk("rst_res16", {15'd0, borrow16, diff16}, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    op(0, 16'd5, 16'd3, 17'h00002);
    op(0, 16'd3, 16'd5, 17'h001FE);
    op(0, 16'h00, 16'hFF, 17'h00101);
    op(0, 16'hA5, 16'hA5, 17'h00000);
    op(1, 16'h0001, 16'h0002, 17'h1FFFF);
    op(1, 16'hFFFF, 16'h0001, 17'h0FFFE);

    // start mid-RUN must be dropped
    @(negedge clk);
    a8 = 8'd9; b8 = 8'd4; start8 = 1'b1;
    @(posedge clk);
    #1;
    start8 = 1'b0;
    q8.push_back('{17'h00005, cyc + 8});
    repeat (3) @(negedge clk);
    a8 = 8'd1; b8 = 8'd2; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    repeat (5) @(negedge clk);
    @(negedge clk);
    chk("ign_idle_busy", {31'd0, busy8}, 0);
    chk("ign_idle_done", {31'd0, done8}, 0);

    // start held high: back-to-back with no IDLE gap
    @(negedge clk);
    a8 = 8'd10; b8 = 8'd1; start8 = 1'b1;
    @(posedge clk);
    #1;
    t0 = cyc;
    q8.push_back('{17'h00009, t0 + 8});
    q8.push_back('{17'h001F7, t0 + 17});
    repeat (8) @(negedge clk);
    @(negedge clk);
    chk("b2b_done1", {31'd0, done8}, 1);
    a8 = 8'd1; b8 = 8'd10;
    @(posedge clk);
    #1;
    start8 = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("b2b_busy2", {31'd0, busy8}, 1);
    end
    @(negedge clk);
    chk("b2b_done2", {31'd0, done8}, 1);

    // asynchronous abort mid-RUN
    @(negedge clk);
    a8 = 8'd200; b8 = 8'd7; start8 = 1'b1;
    @(posedge clk);
    #1;
    start8 = 1'b0;
    repeat (4) @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("abort_busy", {31'd0, busy8}, 0);
    chk("abort_done", {31'd0, done8}, 0);
    chk("abort_res", {23'd0, borrow8, diff8}, 0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      chk("abort_nodone", {30'd0, busy8, done8}, 0);
    end
    op(0, 16'd200, 16'd7, 17'h000C1);

    for (int i = 0; i < 1000; i++) begin
      a8 = 8'($urandom);
      b8 = 8'($urandom);
      m8 = {1'b0, a8} - {1'b0, b8};
      op(0, {8'd0, a8}, {8'd0, b8}, {8'd0, m8});
    end
    for (int i = 0; i < 1000; i++) begin
      a16 = 16'($urandom);
      b16 = 16'($urandom);
      m16 = {1'b0, a16} - {1'b0, b16};
      op(1, a16, b16, m16);
    end

    repeat (3) @(negedge clk);
    chk("q8_drained", q8.size(), 0);
    chk("q16_drained", q16.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
